// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for the ID/EX boundary: datapath widths and the
// bundle of fields that travel from decode into execute.
package id_ex_stage_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [RADDR_W-1:0] rd_addr;
    logic               wb_en;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
  } id_ex_bundle_t;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Combinational forwarding priority mux: picks the youngest writeback source
// whose destination matches addr; x0 never matches.
module id_ex_stage_fwd_sel #(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0]         addr,
  input  logic [XLEN-1:0]            dflt,
  input  logic [NUM_FWD-1:0]         fwd_en,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd_addr,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  output logic [XLEN-1:0]            data,
  output logic                       hit
);

  // Walk from oldest to youngest so the lowest matching index is written last.
  always_comb begin
    data = dflt;
    hit  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_en[i] && (fwd_rd_addr[i*RADDR_W +: RADDR_W] == addr) && (addr != '0)) begin
        data = fwd_data[i*XLEN +: XLEN];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Elastic ID/EX pipeline register with operand forwarding on capture and
// re-snooping while stalled. Optional counters: define ID_EX_PERF_EN.
module id_ex_stage #(
  parameter int XLEN    = id_ex_stage_pkg::XLEN,
  parameter int NUM_FWD = 2,
  parameter int RADDR_W = id_ex_stage_pkg::RADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  output logic                       id_ready,
  input  logic [XLEN-1:0]            id_pc,
  input  logic [XLEN-1:0]            id_imm,
  input  logic [RADDR_W-1:0]         id_rs1_addr,
  input  logic [RADDR_W-1:0]         id_rs2_addr,
  input  logic [RADDR_W-1:0]         id_rd_addr,
  input  logic                       id_wb_en,
  input  logic [XLEN-1:0]            id_rs1_data,
  input  logic [XLEN-1:0]            id_rs2_data,
  input  logic                       flush,
  input  logic [NUM_FWD-1:0]         fwd_en,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd_addr,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output logic [XLEN-1:0]            ex_pc,
  output logic [XLEN-1:0]            ex_imm,
  output logic [RADDR_W-1:0]         ex_rd_addr,
  output logic                       ex_wb_en,
  output logic [XLEN-1:0]            ex_rs1_data,
`ifdef ID_EX_PERF_EN
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_bubble_cnt,
`endif
  output logic [XLEN-1:0]            ex_rs2_data
);

  // Handshake: a transfer into the stage happens on an edge where
  // id_valid && id_ready; a transfer out happens where ex_valid && ex_ready.
  // id_ready never looks at id_valid, and flush overrides every transfer in.
  logic               load;
  logic               hold;
  logic [RADDR_W-1:0] rs1_addr_q, rs2_addr_q;
  logic [RADDR_W-1:0] rs1_sel_addr, rs2_sel_addr;
  logic [XLEN-1:0]    rs1_dflt, rs2_dflt;
  logic [XLEN-1:0]    rs1_fwd, rs2_fwd;
  logic               rs1_hit, rs2_hit;

  assign id_ready = !ex_valid || ex_ready;
  assign load     = id_valid && id_ready && !flush;
  assign hold     = ex_valid && !ex_ready;

  // Same muxes serve both capture and re-snoop; only the address/default source changes.
  assign rs1_sel_addr = load ? id_rs1_addr : rs1_addr_q;
  assign rs2_sel_addr = load ? id_rs2_addr : rs2_addr_q;
  assign rs1_dflt     = load ? id_rs1_data : ex_rs1_data;
  assign rs2_dflt     = load ? id_rs2_data : ex_rs2_data;

  id_ex_stage_fwd_sel #(
    .NUM_FWD (NUM_FWD),
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W)
  ) u_fwd_rs1 (
    .addr        (rs1_sel_addr),
    .dflt        (rs1_dflt),
    .fwd_en      (fwd_en),
    .fwd_rd_addr (fwd_rd_addr),
    .fwd_data    (fwd_data),
    .data        (rs1_fwd),
    .hit         (rs1_hit)
  );

  id_ex_stage_fwd_sel #(
    .NUM_FWD (NUM_FWD),
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W)
  ) u_fwd_rs2 (
    .addr        (rs2_sel_addr),
    .dflt        (rs2_dflt),
    .fwd_en      (fwd_en),
    .fwd_rd_addr (fwd_rd_addr),
    .fwd_data    (fwd_data),
    .data        (rs2_fwd),
    .hit         (rs2_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rd_addr  <= '0;
      ex_wb_en    <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      ex_rd_addr  <= id_rd_addr;
      ex_wb_en    <= id_wb_en;
      ex_rs1_data <= rs1_fwd;
      ex_rs2_data <= rs2_fwd;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
    end else if (hold) begin
      // A stalled instruction keeps tracking producers that retire under it.
      if (rs1_hit) ex_rs1_data <= rs1_fwd;
      if (rs2_hit) ex_rs2_data <= rs2_fwd;
    end else if (ex_valid) begin
      ex_valid <= 1'b0;
    end
  end

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (ex_valid && !ex_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!ex_valid && !flush && (perf_bubble_cnt != '1))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Parametrised, elastic ID/EX pipeline register between the decode stage and the execute stage.
- Uses a valid/ready handshake and registers PC, immediate, destination and the two source operands.
- Resolves operand forwarding from NUM_FWD prioritised writeback sources when an instruction is captured.
- Keeps re-snooping those sources while the instruction is held by an EX stall, so held operands never go stale.
- Supports a flush that inserts a bubble.

Parameters:
- XLEN, 32, data/PC/immediate width.
- NUM_FWD, 2, number of forwarding sources; index 0 = youngest (EX/MEM), highest index = oldest (WB).
- RADDR_W, 5, register-address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage can accept this cycle
- id_pc  in  XLEN  instruction PC
- id_imm  in  XLEN  decoded immediate
- id_rs1_addr  in  RADDR_W  source 1 index
- id_rs2_addr  in  RADDR_W  source 2 index
- id_rd_addr  in  RADDR_W  destination index
- id_wb_en  in  1  instruction writes rd
- id_rs1_data  in  XLEN  register-file read, source 1
- id_rs2_data  in  XLEN  register-file read, source 2
- flush  in  1  kill the stage contents (branch redirect)
- fwd_en  in  NUM_FWD  per-source write enable
- fwd_rd_addr  in  NUM_FWD*RADDR_W  per-source destination, packed with source i at bits [i*RADDR_W +: RADDR_W]
- fwd_data  in  NUM_FWD*XLEN  per-source result, packed likewise
- ex_valid  out  1  stage holds a live instruction
- ex_ready  in  1  execute consumes this cycle
- ex_pc, ex_imm  out  XLEN  registered PC and immediate
- ex_rd_addr  out  RADDR_W  registered destination
- ex_wb_en  out  1  registered write flag
- ex_rs1_data, ex_rs2_data  out  XLEN  registered, forwarded operands

Behaviour:
- Reset: every output register is 0, including ex_valid, ex_wb_en and all data. The internally stored rs1/rs2 addresses are also 0. Reset is asynchronous and valid mid-transfer; the held instruction is lost.
- id_ready = !ex_valid || ex_ready. It is combinational and does not depend on id_valid.
- Load: a load occurs when id_valid && id_ready && !flush. All fields are captured next edge; ex_valid goes to 1. Latency is 1 cycle.
- Drain: ex_valid && ex_ready with no load means ex_valid goes to 0 next edge. Data registers hold their values.
- Hold: ex_valid && !ex_ready means all fields hold, except operands, which are updated by re-snoop.
- Flush: ex_valid goes to 0 next edge regardless of id_valid or ex_ready. A concurrent load is discarded. flush has priority over load, hold and drain.
- Forwarding match for operand k against source i: fwd_en[i] && fwd_rd_addr[i] == addr_k && addr_k != 0.
  - The lowest matching index wins.
  - If nothing matches, the operand uses id_rsk_data on load, or keeps its held value during hold.
- On load, matches are evaluated against id_rs*_addr. During hold, they are evaluated against the stored rs*_addr.
- An instruction with rs = x0 always receives the register-file value.
- Forwarding does not depend on ex_valid.
- A stage that is empty, not loading and not flushing leaves every register unchanged.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt and perf_bubble_cnt, each 32 bits.
  - perf_stall_cnt increments each cycle with ex_valid && !ex_ready.
  - perf_bubble_cnt increments each cycle that ex_valid is 0 and flush is 0.
  - Both reset to 0 and saturate at all-ones.
- Undefined: the ports and counters do not exist, and function is otherwise identical.

Decomposition:
- Shared package (the existing core package) holds:
  - XLEN and RADDR_W constants
  - typedef id_ex_bundle_t, a struct of pc, imm, rd_addr, wb_en, rs1_data, rs2_data
- Natural sub-module: fwd_sel.
  - Purely combinational priority mux with parameters NUM_FWD, XLEN, RADDR_W.
  - Inputs are an address, a default value and the forwarding buses.
  - Outputs are the selected value and a hit flag.
  - It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset mid-hold: rst asserted with ex_valid=1 -> all outputs 0 immediately (asynchronously), id_ready=1.
- Priority: load with rs1=5, rs1_data=0x11. Inputs fwd_en=2'b11, fwd_rd_addr={5,5}, fwd_data={0xBBBB,0xAAAA}, where fwd_data[0]=0xAAAA. Required: ex_rs1_data=0xAAAA. Second case with rs2=0 and a source writing x0 -> ex_rs2_data = register value.
- Stall re-snoop: load rs2=7, rs2_data=0x1 with no match, then hold ex_ready=0 for 3 cycles. In cycle 2, fwd_en[1]=1, rd=7, data=0x55. Required: ex_rs2_data=0x55 from the next edge, pc/imm unchanged, id_ready=0 throughout.
- Flush priority: ex_valid=1, ex_ready=0, id_valid=1, flush=1 -> ex_valid=0 next cycle and the new PC is not captured. The following cycle, id_valid=1 loads normally.
- Back-to-back throughput: id_valid=1 and ex_ready=1 for 8 cycles with PCs 0x0,0x4..0x1C -> ex_pc follows with 1-cycle latency, no bubbles, id_ready constantly 1.
- ID_EX_PERF_EN: 4 stall cycles plus 2 empty cycles -> perf_stall_cnt=4, perf_bubble_cnt=2.
